apb_to_ram_bridge: RTL and testbench

- APB4 completer that converts each APB transfer into one single-beat access on the RAM request/response port (en/we/addr/din out; busy/dout/err in).
- Sits directly upstream of the RAM slave and drives its master side.
- Adds address-window checking, zero-strobe write suppression and a busy timeout, so the APB bus never hangs on a stuck RAM.

---
 rtl/apb_to_ram_bridge_pkg.sv | 28 ++
 rtl/apb_to_ram_bridge_if.sv | 27 ++
 rtl/apb_to_ram_bridge.sv | 162 ++++++++++++++++
 tb/tb_apb_to_ram_bridge.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_to_ram_bridge_pkg.sv
// Shared types and helpers for the APB-to-RAM bridge.
package apb_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned STRB_W         = DEF_DATA_WIDTH / 8;

  // Inclusive-low / exclusive-high window test done one bit wider than the
  // address so that base + bytes cannot wrap past the top of the space.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [64:0] bytes);
    logic [64:0] a;
    logic [64:0] lo;
    logic [64:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + bytes;
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/apb_to_ram_bridge_if.sv
// APB4 bus bundle; the bridge attaches as the slave (completer).
interface apb_to_ram_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic                      pready;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_to_ram_bridge.sv
// APB4 completer turning each transfer into one single-beat RAM access,
// with window/alignment checking, zero-strobe write suppression and a
// busy timeout. All outputs are registered.
module apb_to_ram_bridge
  import apb_ram_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH     = 32,
  parameter int unsigned             DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR      = 32'h0000_0000,
  parameter longint unsigned         RAM_BYTES      = 4096,
  parameter int unsigned             TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  apb_to_ram_bridge_if.slave         apb,
  output logic                       ram_en,
  output logic [DATA_WIDTH/8-1:0]    ram_we,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_din,
  input  logic                       ram_busy,
  input  logic [DATA_WIDTH-1:0]      ram_dout,
  input  logic                       ram_err
);

  localparam int unsigned SW    = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(SW);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           strb_q, strb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    en_d;
  logic [SW-1:0]           we_d;
  logic [ADDR_WIDTH-1:0]   raddr_d;
  logic [DATA_WIDTH-1:0]   din_d;
  logic                    pready_d;
  logic [DATA_WIDTH-1:0]   prdata_d;
  logic                    pslverr_d;

  logic                    addr_ok;

  assign addr_ok = in_window(64'(apb.paddr), 64'(BASE_ADDR), 65'(RAM_BYTES))
                   && (apb.paddr[LSB-1:0] == '0);

  // Next-state, latched-transfer and registered-output computation.
  // RESP launches pready on its exit edge, so the captured response is held
  // in rdata_q/err_q until then and both error and normal paths share it.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    en_d      = 1'b0;
    we_d      = '0;
    raddr_d   = '0;
    din_d     = '0;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          addr_d  = apb.paddr;
          write_d = apb.pwrite;
          wdata_d = apb.pwdata;
          strb_d  = apb.pstrb;
          rdata_d = '0;
          if (!addr_ok) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (apb.pwrite && (apb.pstrb == '0)) begin
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!ram_busy) begin
          en_d    = 1'b1;
          we_d    = write_q ? strb_q : '0;
          raddr_d = addr_q - BASE_ADDR;
          din_d   = wdata_q;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!ram_busy) begin
          rdata_d = write_q ? '0 : ram_dout;
          err_d   = ram_err;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        pready_d  = 1'b1;
        prdata_d  = rdata_q;
        pslverr_d = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched transfer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= '0;
      ram_addr    <= '0;
      ram_din     <= '0;
      apb.pready  <= 1'b0;
      apb.prdata  <= '0;
      apb.pslverr <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ram_en      <= en_d;
      ram_we      <= we_d;
      ram_addr    <= raddr_d;
      ram_din     <= din_d;
      apb.pready  <= pready_d;
      apb.prdata  <= prdata_d;
      apb.pslverr <= pslverr_d;
    end
  end

endmodule

// File: tb/tb_apb_to_ram_bridge.sv
// Directed self-checking bench for apb_to_ram_bridge.
module tb_apb_to_ram_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic clk;
  logic rst;

  logic           ram_en;
  logic [DW/8-1:0] ram_we;
  logic [AW-1:0]  ram_addr;
  logic [DW-1:0]  ram_din;
  logic           ram_busy;
  logic [DW-1:0]  ram_dout;
  logic           ram_err;

  apb_to_ram_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_to_ram_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .BASE_ADDR      (32'h0000_1000),
    .RAM_BYTES      (4096),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .apb      (apb),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_busy (ram_busy),
    .ram_dout (ram_dout),
    .ram_err  (ram_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // RAM model controls (written only by the main sequence)
  int           rsp_lat   = 0;
  logic [DW-1:0] rsp_dout = '0;
  logic         rsp_err   = 1'b0;
  logic         stuck     = 1'b0;

  // Request monitor results (written only by the monitor)
  int            en_cnt    = 0;
  int            zero_viol = 0;
  logic [DW/8-1:0] cap_we   = '0;
  logic [AW-1:0] cap_addr  = '0;
  logic [DW-1:0] cap_din   = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: reacts on the falling edge so busy/dout are stable for the
  // next rising edge.
  initial begin
    int rem;
    rem      = 0;
    ram_busy = 1'b0;
    ram_dout = '0;
    ram_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (ram_en) begin
        if (stuck) begin
          ram_busy = 1'b1;
        end else if (rsp_lat == 0) begin
          ram_busy = 1'b0;
          ram_dout = rsp_dout;
          ram_err  = rsp_err;
        end else begin
          ram_busy = 1'b1;
          rem      = rsp_lat;
        end
      end else if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          ram_busy = 1'b0;
          ram_dout = rsp_dout;
          ram_err  = rsp_err;
        end
      end else if (!stuck) begin
        ram_busy = 1'b0;
      end
    end
  end

  // Request monitor
  initial begin
    forever begin
      @(negedge clk);
      if (ram_en) begin
        en_cnt   = en_cnt + 1;
        cap_we   = ram_we;
        cap_addr = ram_addr;
        cap_din  = ram_din;
      end else if (ram_we != '0 || ram_addr != '0 || ram_din != '0) begin
        zero_viol = zero_viol + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One APB transfer starting just after a rising edge; lat counts rising
  // edges after the setup edge until pready is seen.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW/8-1:0] s, output int lat, output logic [DW-1:0] rd,
                      output logic er, output int np);
    int k;
    int c0;
    c0 = en_cnt;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = w;
    apb.paddr   = a;
    apb.pwdata  = d;
    apb.pstrb   = s;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    k = 0;
    while (k < 100) begin
      @(posedge clk); #1;
      k = k + 1;
      if (apb.pready) break;
    end
    lat = k;
    rd  = apb.prdata;
    er  = apb.pslverr;
    np  = en_cnt - c0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int np;
    int c0;
    int k;
    logic [DW-1:0] rd;
    logic er;

    rst         = 1'b1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pstrb   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", 64'(apb.pready), 64'd0);
    chk("rst_prdata", 64'(apb.prdata), 64'd0);
    chk("rst_pslverr", 64'(apb.pslverr), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait write; RAM dout is non-zero but must not reach prdata
    rsp_lat = 0; rsp_dout = 32'h1234_5678; rsp_err = 1'b0;
    xfer(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, lat, rd, er, np);
    chk("wr_lat", 64'(lat), 64'd3);
    chk("wr_err", 64'(er), 64'd0);
    chk("wr_prdata", 64'(rd), 64'd0);
    chk("wr_pulses", 64'(np), 64'd1);
    chk("wr_we", 64'(cap_we), 64'hF);
    chk("wr_addr", 64'(cap_addr), 64'h10);
    chk("wr_din", 64'(cap_din), 64'hDEAD_BEEF);
    chk("wr_pready_drop", 64'(apb.pready), 64'd0);

    // Read with busy held for five sampled cycles
    rsp_lat = 5; rsp_dout = 32'hDEAD_BEEF;
    xfer(1'b0, 32'h0000_1010, 32'h0, 4'h0, lat, rd, er, np);
    chk("rd_lat", 64'(lat), 64'd8);
    chk("rd_data", 64'(rd), 64'hDEAD_BEEF);
    chk("rd_err", 64'(er), 64'd0);
    chk("rd_we", 64'(cap_we), 64'h0);
    chk("rd_addr", 64'(cap_addr), 64'h10);

    // Window and alignment errors
    rsp_lat = 0;
    xfer(1'b0, 32'h0000_2000, 32'h0, 4'h0, lat, rd, er, np);
    chk("oow_hi_lat", 64'(lat), 64'd1);
    chk("oow_hi_err", 64'(er), 64'd1);
    chk("oow_hi_pulses", 64'(np), 64'd0);
    xfer(1'b0, 32'h0000_1002, 32'h0, 4'h0, lat, rd, er, np);
    chk("misal_lat", 64'(lat), 64'd1);
    chk("misal_err", 64'(er), 64'd1);
    chk("misal_pulses", 64'(np), 64'd0);
    xfer(1'b1, 32'h0000_0FFC, 32'h1, 4'hF, lat, rd, er, np);
    chk("oow_lo_err", 64'(er), 64'd1);
    chk("oow_lo_pulses", 64'(np), 64'd0);

    // Last word of the window is legal
    rsp_dout = 32'h5A5A_A5A5;
    xfer(1'b0, 32'h0000_1FFC, 32'h0, 4'h0, lat, rd, er, np);
    chk("last_lat", 64'(lat), 64'd3);
    chk("last_err", 64'(er), 64'd0);
    chk("last_data", 64'(rd), 64'h5A5A_A5A5);
    chk("last_addr", 64'(cap_addr), 64'hFFC);

    // Zero-strobe write completes OKAY without touching the RAM
    xfer(1'b1, 32'h0000_1020, 32'hFFFF_FFFF, 4'h0, lat, rd, er, np);
    chk("zstrb_lat", 64'(lat), 64'd1);
    chk("zstrb_err", 64'(er), 64'd0);
    chk("zstrb_pulses", 64'(np), 64'd0);

    // RAM error reported at completion
    rsp_err = 1'b1;
    xfer(1'b1, 32'h0000_1040, 32'h0000_00AB, 4'h3, lat, rd, er, np);
    chk("ramerr_lat", 64'(lat), 64'd3);
    chk("ramerr_err", 64'(er), 64'd1);
    chk("ramerr_we", 64'(cap_we), 64'h3);
    chk("ramerr_din", 64'(cap_din), 64'hAB);
    rsp_err = 1'b0;

    // Busy stuck after issue: forced error after TO WAIT cycles
    stuck = 1'b1;
    xfer(1'b0, 32'h0000_1020, 32'h0, 4'h0, lat, rd, er, np);
    chk("to_lat", 64'(lat), 64'(TO + 2));
    chk("to_err", 64'(er), 64'd1);
    chk("to_prdata", 64'(rd), 64'd0);
    chk("to_pulses", 64'(np), 64'd1);

    // Next transfer must wait in ISSUE until busy drops
    rsp_dout    = 32'hCAFE_F00D;
    c0          = en_cnt;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = 32'h0000_1024;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("hold_no_issue", 64'(en_cnt - c0), 64'd0);
    chk("hold_no_pready", 64'(apb.pready), 64'd0);
    stuck = 1'b0;
    k = 0;
    while (k < 100) begin
      @(posedge clk); #1;
      k = k + 1;
      if (apb.pready) break;
    end
    chk("hold_release_lat", 64'(k), 64'd3);
    chk("hold_data", 64'(apb.prdata), 64'hCAFE_F00D);
    chk("hold_err", 64'(apb.pslverr), 64'd0);
    chk("hold_pulses", 64'(en_cnt - c0), 64'd1);
    chk("hold_addr", 64'(cap_addr), 64'h24);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    @(posedge clk); #1;

    // Reset while waiting on a stuck RAM
    stuck       = 1'b1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = 32'h0000_1030;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_pready", 64'(apb.pready), 64'd0);
    chk("mrst_prdata", 64'(apb.prdata), 64'd0);
    chk("mrst_pslverr", 64'(apb.pslverr), 64'd0);
    chk("mrst_ram_en", 64'(ram_en), 64'd0);
    rst         = 1'b0;
    stuck       = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rsp_dout = 32'h0BAD_C0DE;
    xfer(1'b0, 32'h0000_1030, 32'h0, 4'h0, lat, rd, er, np);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_data", 64'(rd), 64'h0BAD_C0DE);
    chk("post_rst_err", 64'(er), 64'd0);
    chk("post_rst_pulses", 64'(np), 64'd1);

    chk("idle_outputs_zero", 64'(zero_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
